// File: rtl/fb_ram_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port RAM between VGA scan-out reads,
// a valid/ready pixel writer and a full-buffer clear engine (display > clear > writer).
module fb_ram_arbiter #(
   parameter int DWORD  = 16384,
   parameter int DWIDTH = 12,
   parameter int AWIDTH = $clog2(DWORD + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [AWIDTH-1:0] disp_addr,
   output logic              disp_rvalid,
   output logic [DWIDTH-1:0] disp_rdata,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              wr_oob,
   input  logic              clr_start,
   input  logic [DWIDTH-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   input  logic [DWIDTH-1:0] ram_dout
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AWIDTH-1:0] DEPTH = AWIDTH'(DWORD);
   localparam logic [AWIDTH-1:0] LAST  = AWIDTH'(DWORD - 1);

   state_t            state, state_next;
   logic [AWIDTH-1:0] clr_cnt, clr_cnt_next;
   logic [DWIDTH-1:0] clr_col;
   logic              clr_load;
   logic              clr_last;
   logic              oob_beat;
   logic              rd_in_range;

   // Grant selection: display always wins, clear uses the leftover cycles,
   // the writer only gets cycles while no clear is running.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      clr_load     = 1'b0;
      clr_last     = 1'b0;
      oob_beat     = 1'b0;
      wr_ready     = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_din      = '0;
      if (!rst) begin
         if (disp_req) begin
            ram_addr = disp_addr;
         end else if (state == CLEAR) begin
            ram_we       = 1'b1;
            ram_addr     = clr_cnt;
            ram_din      = clr_col;
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == LAST) begin
               clr_last     = 1'b1;
               clr_cnt_next = '0;
               state_next   = IDLE;
            end
         end else begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               if (wr_addr < DEPTH) begin
                  ram_we   = 1'b1;
                  ram_addr = wr_addr;
                  ram_din  = wr_data;
               end else begin
                  oob_beat = 1'b1;
               end
            end
         end
         // A start request is honoured even on a cycle the display owns.
         if (state == IDLE && clr_start) begin
            clr_load     = 1'b1;
            clr_cnt_next = '0;
            state_next   = CLEAR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         clr_cnt     <= '0;
         clr_col     <= '0;
         clr_done    <= 1'b0;
         wr_oob      <= 1'b0;
         disp_rvalid <= 1'b0;
         rd_in_range <= 1'b0;
      end else begin
         state       <= state_next;
         clr_cnt     <= clr_cnt_next;
         clr_done    <= clr_last;
         wr_oob      <= oob_beat;
         disp_rvalid <= disp_req;
         rd_in_range <= (disp_addr < DEPTH);
         if (clr_load) begin
            clr_col <= clr_color;
         end
      end
   end

   assign clr_busy = (state == CLEAR);

   // Out-of-range reads still return a valid beat, but with zero data.
   assign disp_rdata = (disp_rvalid && rd_in_range) ? ram_dout : '0;

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Self-checking bench for fb_ram_arbiter: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model and a backing RAM model.
module tb_fb_ram_arbiter;

   localparam int DWORD  = 16;
   localparam int DWIDTH = 12;
   localparam int AWIDTH = $clog2(DWORD + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              disp_req;
   logic [AWIDTH-1:0] disp_addr;
   logic              disp_rvalid;
   logic [DWIDTH-1:0] disp_rdata;
   logic              wr_valid;
   logic              wr_ready;
   logic [AWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic              wr_oob;
   logic              clr_start;
   logic [DWIDTH-1:0] clr_color;
   logic              clr_busy;
   logic              clr_done;
   logic              ram_we;
   logic [AWIDTH-1:0] ram_addr;
   logic [DWIDTH-1:0] ram_din;
   logic [DWIDTH-1:0] ram_dout;

   logic [DWIDTH-1:0] ram_mem [DWORD];
   logic [DWIDTH-1:0] ref_mem [DWORD];

   bit                m_busy;
   int                m_cnt;
   logic [DWIDTH-1:0] m_color;

   int n_checks = 0;
   int n_fail   = 0;

   fb_ram_arbiter #(.DWORD(DWORD), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_oob(wr_oob),
      .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Single-port RAM with registered read (read-before-write).
   always @(posedge clk) begin
      if (ram_we && ram_addr < DWORD) ram_mem[ram_addr] <= ram_din;
      ram_dout <= (ram_addr < DWORD) ? ram_mem[ram_addr] : '0;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      rst = 1'b0; disp_req = 1'b0; disp_addr = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      clr_start = 1'b0; clr_color = '0;
   endtask

   // One clock cycle: predict from the model, check combinational outputs mid-cycle,
   // then advance the model across the edge and check registered outputs.
   task automatic applyStimulus();
      logic              e_we, e_ready, e_rvalid, e_oob, e_done;
      logic [AWIDTH-1:0] e_addr;
      logic [DWIDTH-1:0] e_din, e_rdata;
      e_we = 0; e_ready = 0; e_rvalid = 0; e_oob = 0; e_done = 0;
      e_addr = '0; e_din = '0; e_rdata = '0;
      if (!rst) begin
         e_rvalid = disp_req;
         if (disp_req) begin
            e_addr = disp_addr;
            if (disp_addr < DWORD) e_rdata = ref_mem[disp_addr];
         end else if (m_busy) begin
            e_we = 1; e_addr = AWIDTH'(m_cnt); e_din = m_color;
            e_done = (m_cnt == DWORD - 1);
         end else begin
            e_ready = 1;
            if (wr_valid) begin
               if (wr_addr < DWORD) begin
                  e_we = 1; e_addr = wr_addr; e_din = wr_data;
               end else begin
                  e_oob = 1;
               end
            end
         end
      end
      #3;
      checkOutput("wr_ready", 32'(wr_ready), 32'(e_ready));
      checkOutput("ram_we",   32'(ram_we),   32'(e_we));
      checkOutput("ram_addr", 32'(ram_addr), 32'(e_addr));
      checkOutput("ram_din",  32'(ram_din),  32'(e_din));
      @(posedge clk);
      #1;
      if (e_we) ref_mem[e_addr] = e_din;
      if (rst) begin
         m_busy = 0; m_cnt = 0; m_color = '0;
      end else if (m_busy) begin
         if (!disp_req) begin
            if (m_cnt == DWORD - 1) begin
               m_busy = 0; m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
      end else if (clr_start) begin
         m_busy = 1; m_cnt = 0; m_color = clr_color;
      end
      checkOutput("disp_rvalid", 32'(disp_rvalid), 32'(e_rvalid));
      checkOutput("disp_rdata",  32'(disp_rdata),  32'(e_rdata));
      checkOutput("wr_oob",      32'(wr_oob),      32'(e_oob));
      checkOutput("clr_done",    32'(clr_done),    32'(e_done));
      checkOutput("clr_busy",    32'(clr_busy),    32'(m_busy));
   endtask

   task automatic readAll();
      for (int a = 0; a < DWORD; a++) begin
         idleInputs(); disp_req = 1'b1; disp_addr = AWIDTH'(a);
         applyStimulus();
      end
      idleInputs();
   endtask

   initial begin
      int busy_cycles, done_pulses;
      bit pend;
      for (int a = 0; a < DWORD; a++) begin
         ram_mem[a] = '0; ref_mem[a] = '0;
      end
      m_busy = 0; m_cnt = 0; m_color = '0;
      idleInputs();
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset: writer and clear requests must be ignored
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 12'h555; clr_start = 1'b1;
      applyStimulus();
      applyStimulus();
      idleInputs();
      applyStimulus();

      // Write 0xABC to 5, read it back
      wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 12'hABC;
      applyStimulus();
      idleInputs(); disp_req = 1'b1; disp_addr = 5'd5;
      applyStimulus();
      checkOutput("t_wr5_rdata", 32'(disp_rdata), 32'h0ABC);
      idleInputs();

      // Display and writer collide: writer waits one cycle
      disp_req = 1'b1; disp_addr = 5'd7; wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 12'h123;
      applyStimulus();
      disp_req = 1'b0;
      applyStimulus();
      idleInputs(); disp_req = 1'b1; disp_addr = 5'd7;
      applyStimulus();
      checkOutput("t_wr7_rdata", 32'(disp_rdata), 32'h0123);
      idleInputs();

      // Clear without display traffic
      clr_start = 1'b1; clr_color = 12'hF00;
      applyStimulus();
      idleInputs();
      busy_cycles = clr_busy ? 1 : 0; done_pulses = 0;
      for (int i = 0; i < 100 && clr_busy; i++) begin
         applyStimulus();
         if (clr_busy) busy_cycles++;
         if (clr_done) done_pulses++;
      end
      checkOutput("clr1_busy_len", 32'(busy_cycles), 32'd16);
      checkOutput("clr1_done_cnt", 32'(done_pulses), 32'd1);
      readAll();

      // Clear with display on alternate cycles
      clr_start = 1'b1; clr_color = 12'hF00;
      applyStimulus();
      idleInputs();
      busy_cycles = clr_busy ? 1 : 0; done_pulses = 0;
      for (int i = 0; i < 200 && clr_busy; i++) begin
         disp_req = (i % 2 == 0); disp_addr = AWIDTH'($urandom_range(0, DWORD - 1));
         applyStimulus();
         if (clr_busy) busy_cycles++;
         if (clr_done) done_pulses++;
      end
      idleInputs();
      checkOutput("clr2_busy_len", 32'(busy_cycles), 32'd32);
      checkOutput("clr2_done_cnt", 32'(done_pulses), 32'd1);
      readAll();

      // Out-of-range write and read
      wr_valid = 1'b1; wr_addr = AWIDTH'(DWORD); wr_data = 12'h777;
      applyStimulus();
      checkOutput("t_oob_pulse", 32'(wr_oob), 32'd1);
      idleInputs(); disp_req = 1'b1; disp_addr = AWIDTH'(DWORD);
      applyStimulus();
      checkOutput("t_oob_rdata", 32'(disp_rdata), 32'h0);
      idleInputs();

      // Reset in the middle of a clear, then restart from address 0
      wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 12'h0AA;
      applyStimulus();
      idleInputs();
      clr_start = 1'b1; clr_color = 12'h00F;
      applyStimulus();
      idleInputs();
      for (int i = 0; i < 8; i++) applyStimulus();
      rst = 1'b1;
      applyStimulus();
      checkOutput("t_rst_busy", 32'(clr_busy), 32'd0);
      idleInputs();
      applyStimulus();
      checkOutput("t_rst_done", 32'(clr_done), 32'd0);
      clr_start = 1'b1; clr_color = 12'h0F0;
      applyStimulus();
      idleInputs();
      busy_cycles = clr_busy ? 1 : 0; done_pulses = 0;
      for (int i = 0; i < 100 && clr_busy; i++) begin
         applyStimulus();
         if (clr_busy) busy_cycles++;
         if (clr_done) done_pulses++;
      end
      checkOutput("clr3_busy_len", 32'(busy_cycles), 32'd16);
      checkOutput("clr3_done_cnt", 32'(done_pulses), 32'd1);
      readAll();

      // Random traffic; writer holds its beat until accepted
      pend = 0;
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 79) == 0);
         disp_req  = ($urandom_range(0, 1) == 1);
         disp_addr = AWIDTH'($urandom_range(0, DWORD + 1));
         clr_start = ($urandom_range(0, 59) == 0);
         clr_color = DWIDTH'($urandom);
         if (!pend && $urandom_range(0, 2) != 0) begin
            pend     = 1;
            wr_addr  = AWIDTH'($urandom_range(0, DWORD + 1));
            wr_data  = DWIDTH'($urandom);
         end
         wr_valid = pend;
         if (pend && !rst && !disp_req && !m_busy) pend = 0;
         applyStimulus();
      end
      idleInputs();
      for (int i = 0; i < 100 && clr_busy; i++) applyStimulus();
      checkOutput("rand_clr_end", 32'(clr_busy), 32'd0);
      readAll();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
